// File: rtl/adder_result_stage.sv
// Purpose : registered result stage behind the 16-bit CLA adder; 2-entry skid buffer plus sticky carry/overflow and accept counter.
// Latency : 1 cycle from accept (in_valid & in_ready) to out_valid; sustains 1 result/cycle while out_ready=1.
// Backpressure: in_ready is a flop (low only when both entries are full); out data holds steady while out_valid & !out_ready.
//
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready         producer handshake (adder side)
//   in_sum, in_carry, in_sign,
//   in_zero, in_parrity,
//   in_overflow                 adder result and flags, captured on accept
//   out_valid / out_ready       consumer handshake
//   out_sum, out_flags          head entry; out_flags = {carry,sign,zero,parrity,overflow}
//   clr_sticky                  synchronous clear of sticky_carry / sticky_ovf
//   sticky_carry, sticky_ovf    OR of carry / overflow over accepted results since last clear
//   acc_cnt                     accepted-result count, wraps modulo 2^CNT_W

module adder_result_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_carry,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              in_parrity,
    input  logic              in_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [4:0]        out_flags,
    input  logic              clr_sticky,
    output logic              sticky_carry,
    output logic              sticky_ovf,
    output logic [CNT_W-1:0]  acc_cnt
);

    // One buffered adder result: sum plus {carry,sign,zero,parrity,overflow}.
    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic [4:0]        flags;
    } entry_t;

    // Occupancy of the two-register buffer.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    entry_t           main_q;     // head of queue, drives the outputs
    entry_t           main_d;
    entry_t           skid_q;     // second entry, only used when main is stalled
    entry_t           skid_d;
    entry_t           in_entry;
    logic             in_ready_q;
    logic             accept;
    logic             pop;
    logic             sticky_carry_q;
    logic             sticky_ovf_q;
    logic [CNT_W-1:0] acc_cnt_q;

    assign in_entry.sum   = in_sum;
    assign in_entry.flags = {in_carry, in_sign, in_zero, in_parrity, in_overflow};

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Buffer control. Registers only load on the transitions that need
    // them, so the head entry cannot change while it is being stalled.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_entry;
                end else if (accept) begin
                    // Head is stalled: park the newcomer behind it.
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so accept cannot occur.
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                // Unreachable encoding: recover to empty.
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered ready: computed from next occupancy so the producer
            // never sees a combinational path from out_ready.
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    // ------------------------------------------------------------------
    // Status for the ALU control path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
        end else if (clr_sticky) begin
            // A flag raised by an accept in the same cycle survives the clear.
            sticky_carry_q <= accept & in_carry;
            sticky_ovf_q   <= accept & in_overflow;
        end else begin
            sticky_carry_q <= sticky_carry_q | (accept & in_carry);
            sticky_ovf_q   <= sticky_ovf_q | (accept & in_overflow);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
        end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_sum      = main_q.sum;
    assign out_flags    = main_q.flags;
    assign sticky_carry = sticky_carry_q;
    assign sticky_ovf   = sticky_ovf_q;
    assign acc_cnt      = acc_cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Purpose : self-checking bench for adder_result_stage (scoreboard queue + negedge monitor).
// Latency : expects results one cycle after accept, strict FIFO order.
// Backpressure: exercises fixed and random out_ready, full-buffer stall and reset while full.

module tb_adder_result_stage;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_sum = '0;
    logic          in_carry = 1'b0;
    logic          in_sign = 1'b0;
    logic          in_zero = 1'b0;
    logic          in_parrity = 1'b0;
    logic          in_overflow = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic [4:0]    out_flags;
    logic          clr_sticky = 1'b0;
    logic          sticky_carry;
    logic          sticky_ovf;
    logic [CW-1:0] acc_cnt;

    logic          man_rdy = 1'b0;
    logic          rnd_rdy = 1'b0;
    logic          rand_mode = 1'b0;
    assign out_ready = rand_mode ? rnd_rdy : man_rdy;

    adder_result_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_carry(in_carry), .in_sign(in_sign), .in_zero(in_zero),
        .in_parrity(in_parrity), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags),
        .clr_sticky(clr_sticky), .sticky_carry(sticky_carry),
        .sticky_ovf(sticky_ovf), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of expected results and plain counters.
    logic [20:0] sb[$];
    int          tests = 0;
    int          fails = 0;
    int          pops = 0;
    int          stalls = 0;
    int unsigned acc_m = 0;
    logic        sc_m = 1'b0;
    logic        so_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every pop against the scoreboard and checks stall stability.
    logic        prev_hold = 1'b0;
    logic [20:0] prev_dat = '0;
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_sum, out_flags}), 32'(prev_dat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got %0h expected no entry", {out_sum, out_flags});
                end else begin
                    e = sb.pop_front();
                    chk("pop_data", 32'({out_sum, out_flags}), 32'(e));
                end
                pops++;
            end
            prev_hold = out_valid && !out_ready;
            prev_dat  = {out_sum, out_flags};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid low.
    task automatic send(input logic [15:0] s, input logic [4:0] f);
        logic acc;
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_sum = s;
        {in_carry, in_sign, in_zero, in_parrity, in_overflow} = f;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                sb.push_back({s, f});
                acc_m = (acc_m + 1) % 256;
                if (clr_sticky) begin
                    sc_m = f[4];
                    so_m = f[0];
                end else begin
                    sc_m = sc_m | f[4];
                    so_m = so_m | f[0];
                end
            end else begin
                stalls++;
                if (clr_sticky) begin
                    sc_m = 1'b0;
                    so_m = 1'b0;
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready stuck low expected accept of %0h", s);
        end
        in_valid = 1'b0;
        clr_sticky = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_acc_cnt"}, 32'(acc_cnt), 32'(acc_m));
        chk({tag, "_sticky_carry"}, 32'(sticky_carry), 32'(sc_m));
        chk({tag, "_sticky_ovf"}, 32'(sticky_ovf), 32'(so_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int s0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        check_status("rst");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: single transfer
        man_rdy = 1'b1;
        send(16'h8000, 5'b01010);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'h8000);
        chk("t1_flags", 32'(out_flags), 32'b01010);
        chk("t1_acc_cnt", 32'(acc_cnt), 32'd1);
        idle(1);
        chk("t1_valid_after", 32'(out_valid), 32'd0);

        // 2: back-pressure fills both entries
        man_rdy = 1'b0;
        send(16'h0001, 5'b00000);
        send(16'h0002, 5'b00000);
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_head", 32'(out_sum), 32'h0001);
        man_rdy = 1'b1;
        idle(1);
        chk("t2_second_valid", 32'(out_valid), 32'd1);
        chk("t2_second", 32'(out_sum), 32'h0002);
        idle(1);
        chk("t2_empty", 32'(out_valid), 32'd0);
        chk("t2_in_ready", 32'(in_ready), 32'd1);

        // 3: streaming, back-to-back
        p0 = pops;
        s0 = stalls;
        for (int i = 0; i < 20; i++) send(16'(16'h0100 + i), 5'($urandom_range(0, 31)));
        idle(2);
        chk("t3_stalls", 32'(stalls - s0), 32'd0);
        chk("t3_pops", 32'(pops - p0), 32'd20);
        check_status("t3");

        // 4: sticky flags
        send(16'h8000, 5'b01001);
        chk("t4_ovf_set", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;
        sc_m = 1'b0;
        so_m = 1'b0;
        chk("t4_ovf_clr", 32'(sticky_ovf), 32'd0);
        chk("t4_carry_clr", 32'(sticky_carry), 32'd0);
        clr_sticky = 1'b1;
        send(16'h8000, 5'b01001);
        chk("t4_ovf_clr_wins_new", 32'(sticky_ovf), 32'd1);
        send(16'h0000, 5'b10100);
        chk("t4_carry_set", 32'(sticky_carry), 32'd1);
        clr_sticky = 1'b1;
        send(16'h0005, 5'b00000);
        check_status("t4");

        // 5: counter wrap after 256 accepts
        s0 = int'(acc_cnt);
        for (int i = 0; i < 256; i++) send(16'($urandom), 5'($urandom_range(0, 31)));
        idle(2);
        chk("t5_wrap", 32'(acc_cnt), 32'(s0));
        check_status("t5");

        // Random traffic with random backpressure and occasional clears
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) clr_sticky = 1'b1;
            send(16'($urandom), 5'($urandom_range(0, 31)));
            idle($urandom_range(0, 2));
        end
        rand_mode = 1'b0;
        man_rdy = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) idle(1);
        chk("rand_drain", 32'(sb.size()), 32'd0);
        check_status("rand");

        // 6: reset while full
        man_rdy = 1'b0;
        send(16'hAAAA, 5'b11111);
        send(16'h5555, 5'b10001);
        chk("t6_full", 32'(in_ready), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_sum", 32'(out_sum), 32'd0);
        chk("t6_flags", 32'(out_flags), 32'd0);
        sb.delete();
        acc_m = 0;
        sc_m = 1'b0;
        so_m = 1'b0;
        check_status("t6_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_still_empty", 32'(out_valid), 32'd0);
        man_rdy = 1'b1;
        p0 = pops;
        send(16'h1234, 5'b00100);
        idle(3);
        chk("t6_single_pop", 32'(pops - p0), 32'd1);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        check_status("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
